osc_cal_ctrl: RTL
=================

// Module: osc_cal_ctrl
// PURPOSE
//  Frequency-calibration sequencer for the multiphase ring oscillator core.
//  Powers up the oscillator (glob_en). Runs a 13-bit MSB-first successive-approximation
//  search on the delay code {delay_con_msb, delay_con_lsb} against an external
//  per-window oscillator cycle count, then enables reference injection (inj_en).
//  Sits between the digital config/JTAG registers and osc_core. Runs on ref_clk only.
// PARAMETERS
//  SETTLE_CYC   64    ref_clk cycles waited after every code/enable change (>=1)
//  TIMEOUT_CYC  4096  max cycles in MEAS waiting for meas_valid before error
//  CNT_W        16    width of measured/target oscillator counts
// PORTS
//  ref_clk        in   1      clock
//  rst            in   1      asynchronous reset, active-high
//  cal_start      in   1      start calibration; sampled only in IDLE, DONE or ERR
//  cal_abort      in   1      abort; return to IDLE from any state
//  target_cnt     in   CNT_W  desired osc count per measurement window
//  meas_cnt       in   CNT_W  measured osc count, valid with meas_valid
//  meas_valid     in   1      one-cycle strobe, measurement complete
//  meas_req       out  1      one-cycle strobe, start a measurement window
//  glob_en        out  1      oscillator global enable
//  delay_con_msb  out  8      coarse delay code = code[12:5]
//  delay_con_lsb  out  5      fine delay code = code[4:0]
//  inj_en         out  1      reference injection enable
//  busy           out  1      high in PWRUP..INJ
//  cal_done       out  1      high in DONE
//  cal_err        out  1      high in ERR
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0, including code. bit_idx=12. Counters 0.
//  - All outputs are registered. code[12:0] is internal; the delay_con ports are direct slices.
//  - IDLE: cal_start=1 -> PWRUP. On entry: code<=0, bit_idx<=12, glob_en<=1.
//  - PWRUP: wait SETTLE_CYC cycles -> TRIAL.
//  - TRIAL (1 cycle): code[bit_idx]<=1 -> SETTLE.
//  - SETTLE: wait SETTLE_CYC cycles -> MEAS. meas_req=1 on the first MEAS cycle only.
//  - MEAS: meas_valid ignored on the meas_req cycle itself. Accepted from the next cycle on.
//    - On meas_valid: latch meas_cnt, go to DECIDE.
//    - TIMEOUT_CYC cycles without valid: go to ERR.
//  - DECIDE (1 cycle):
//    - meas_cnt > target_cnt (osc too fast): keep code[bit_idx]=1. Otherwise clear it.
//    - Comparison is unsigned. Equality clears the bit.
//    - bit_idx==0 -> INJ. Else bit_idx<=bit_idx-1 -> TRIAL.
//    - Result: largest code whose count > target. 0 if none.
//  - INJ: inj_en<=1 on entry, wait SETTLE_CYC cycles -> DONE.
//  - DONE: cal_done=1, busy=0. glob_en, inj_en and code are held.
//    cal_start re-enters PWRUP (code cleared, inj_en<=0).
//  - ERR: cal_err=1, glob_en=0, inj_en=0, code held at last trial value.
//    cal_start -> PWRUP.
//  - cal_abort (priority over cal_start and every other transition): next state IDLE.
//    glob_en=0, inj_en=0, meas_req=0, code held. A meas_valid pending at abort is dropped.
//  - meas_valid outside MEAS is ignored. cal_start while busy is ignored.
//  - Per-bit latency: 1 + SETTLE_CYC + (req->valid) + 1 cycles. Exactly 13 meas_req per run.
//  - Settle/timeout counters are sized $clog2(max(SETTLE_CYC,TIMEOUT_CYC)+1) and never wrap.
//  - rst mid-operation: all outputs drop to 0 asynchronously, including glob_en and inj_en.
// TESTING
//  1. Reset: assert rst mid-search -> all outputs 0 immediately; IDLE after release;
//     no meas_req until cal_start.
//  2. Ideal model: meas_cnt=20000-2*code, valid 3 cycles after req, target=12000
//     -> 13 meas_req pulses, final msb=0x7C, lsb=0x1F (code 3999), inj_en=1, cal_done=1.
//  3. Edges: meas_cnt==target always -> code 0x0000.
//     meas_cnt>target always -> code 0x1FFF (msb=0xFF, lsb=0x1F).
//  4. Timeout: never assert meas_valid
//     -> cal_err after TIMEOUT_CYC MEAS cycles, code=0x1000, glob_en=0, one meas_req seen.
//  5. Abort at bit_idx=7, with meas_valid on the same cycle -> IDLE, glob_en=0,
//     code unchanged, valid dropped; then cal_start gives a clean 13-step run.
//  6. Restart from DONE via cal_start -> inj_en drops, code=0, PWRUP; a second run
//     with target=8000 under the model of scenario 2 ends at code 5999 (msb=0xBB, lsb=0x0F).

Source files
------------

// File: rtl/osc_cal_if.sv
// osc_cal_if: handshake/bus bundle between the oscillator calibration sequencer
// and its surroundings (config registers, osc_core and the count-measurement block).
//
// Signals:
//   cal_start      start a calibration run
//   cal_abort      abort the current run, return to IDLE
//   target_cnt     desired oscillator count per measurement window
//   meas_cnt       measured oscillator count, qualified by meas_valid
//   meas_valid     one-cycle strobe, measurement complete
//   meas_req       one-cycle strobe, start a measurement window
//   glob_en        oscillator global enable
//   delay_con_msb  coarse delay code (code[12:5])
//   delay_con_lsb  fine delay code (code[4:0])
//   inj_en         reference injection enable
//   busy           calibration in progress
//   cal_done       calibration finished successfully
//   cal_err        calibration stopped on a measurement timeout
//
// Modports:
//   master  host/environment side (drives commands and measurement results)
//   slave   the calibration sequencer
interface osc_cal_if #(
    parameter int CNT_W = 16
);
    logic             cal_start;
    logic             cal_abort;
    logic [CNT_W-1:0] target_cnt;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_valid;
    logic             meas_req;
    logic             glob_en;
    logic [7:0]       delay_con_msb;
    logic [4:0]       delay_con_lsb;
    logic             inj_en;
    logic             busy;
    logic             cal_done;
    logic             cal_err;

    modport master (
        output cal_start, cal_abort, target_cnt, meas_cnt, meas_valid,
        input  meas_req, glob_en, delay_con_msb, delay_con_lsb, inj_en,
               busy, cal_done, cal_err
    );

    modport slave (
        input  cal_start, cal_abort, target_cnt, meas_cnt, meas_valid,
        output meas_req, glob_en, delay_con_msb, delay_con_lsb, inj_en,
               busy, cal_done, cal_err
    );
endinterface

// File: rtl/osc_cal_ctrl.sv
// osc_cal_ctrl: frequency-calibration sequencer for the multiphase ring oscillator.
// Powers up the oscillator, runs a 13-bit MSB-first successive-approximation
// search on the delay code against an external per-window oscillator count,
// then enables reference injection. Runs entirely on ref_clk.
//
// Ports:
//   ref_clk   clock
//   rst       asynchronous reset, active-high
//   bus       osc_cal_if slave modport (commands, measurement handshake,
//             oscillator controls and status flags)
//
// Parameters:
//   SETTLE_CYC   cycles waited after every code/enable change (>=1)
//   TIMEOUT_CYC  cycles allowed in MEAS before giving up with cal_err
//   CNT_W        width of measured/target oscillator counts
module osc_cal_ctrl #(
    parameter int SETTLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic     ref_clk,
    input  logic     rst,
    osc_cal_if.slave bus
);

    localparam int MAX_WAIT = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_TRIAL,
        S_SETTLE,
        S_MEAS,
        S_DECIDE,
        S_INJ,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [12:0]      r_code;
    logic [3:0]       r_bit_idx;
    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_meas_cnt;
    logic             r_glob_en;
    logic             r_inj_en;
    logic             r_meas_req;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [12:0]      w_code;
    logic [3:0]       w_bit_idx;
    logic [CW-1:0]    w_cnt;
    logic [CNT_W-1:0] w_meas_cnt;
    logic             w_glob_en;
    logic             w_inj_en;
    logic             w_meas_req;
    logic             w_busy;
    logic             w_done;
    logic             w_err;

    logic             w_settle_done;
    logic             w_timeout;
    logic             w_valid_ok;
    logic [12:0]      w_bit_mask;

    assign w_settle_done = (r_cnt == SETTLE_LAST);
    assign w_timeout     = (r_cnt == TIMEOUT_LAST);
    // r_cnt is 0 on the meas_req cycle, so a strobe coinciding with the request is ignored.
    assign w_valid_ok    = bus.meas_valid && (r_cnt != '0);
    assign w_bit_mask    = 13'd1 << r_bit_idx;

    // State register plus registered outputs and datapath.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_code     <= '0;
            r_bit_idx  <= 4'd12;
            r_cnt      <= '0;
            r_meas_cnt <= '0;
            r_glob_en  <= 1'b0;
            r_inj_en   <= 1'b0;
            r_meas_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_code     <= w_code;
            r_bit_idx  <= w_bit_idx;
            r_cnt      <= w_cnt;
            r_meas_cnt <= w_meas_cnt;
            r_glob_en  <= w_glob_en;
            r_inj_en   <= w_inj_en;
            r_meas_req <= w_meas_req;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        if (bus.cal_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (bus.cal_start) w_next_state = S_PWRUP;
                S_PWRUP:               if (w_settle_done) w_next_state = S_TRIAL;
                S_TRIAL:               w_next_state = S_SETTLE;
                S_SETTLE:              if (w_settle_done) w_next_state = S_MEAS;
                S_MEAS: begin
                    if (w_valid_ok)     w_next_state = S_DECIDE;
                    else if (w_timeout) w_next_state = S_ERR;
                end
                S_DECIDE:              w_next_state = (r_bit_idx == 4'd0) ? S_INJ : S_TRIAL;
                S_INJ:                 if (w_settle_done) w_next_state = S_DONE;
                default:               w_next_state = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        w_code     = r_code;
        w_bit_idx  = r_bit_idx;
        w_meas_cnt = r_meas_cnt;
        w_glob_en  = r_glob_en;
        w_inj_en   = r_inj_en;
        w_meas_req = 1'b0;

        // Wait counter restarts on every state change and saturates instead of wrapping.
        if (w_next_state != r_state)
            w_cnt = '0;
        else if (r_cnt != CNT_MAX)
            w_cnt = r_cnt + CW'(1);
        else
            w_cnt = r_cnt;

        if (bus.cal_abort) begin
            w_glob_en = 1'b0;
            w_inj_en  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.cal_start) begin
                        w_code    = '0;
                        w_bit_idx = 4'd12;
                        w_glob_en = 1'b1;
                        w_inj_en  = 1'b0;
                    end
                end
                S_TRIAL: w_code = r_code | w_bit_mask;
                S_SETTLE: begin
                    if (w_settle_done) w_meas_req = 1'b1;
                end
                S_MEAS: begin
                    if (w_valid_ok) begin
                        w_meas_cnt = bus.meas_cnt;
                    end else if (w_timeout) begin
                        w_glob_en = 1'b0;
                        w_inj_en  = 1'b0;
                    end
                end
                S_DECIDE: begin
                    // Keep the trial bit only while the oscillator is still too fast.
                    if (!(r_meas_cnt > bus.target_cnt))
                        w_code = r_code & ~w_bit_mask;
                    if (r_bit_idx == 4'd0)
                        w_inj_en = 1'b1;
                    else
                        w_bit_idx = r_bit_idx - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Status flags follow the state being entered so they line up with it.
    always_comb begin
        w_busy = (w_next_state == S_PWRUP)  || (w_next_state == S_TRIAL) ||
                 (w_next_state == S_SETTLE) || (w_next_state == S_MEAS)  ||
                 (w_next_state == S_DECIDE) || (w_next_state == S_INJ);
        w_done = (w_next_state == S_DONE);
        w_err  = (w_next_state == S_ERR);
    end

    assign bus.meas_req      = r_meas_req;
    assign bus.glob_en       = r_glob_en;
    assign bus.delay_con_msb = r_code[12:5];
    assign bus.delay_con_lsb = r_code[4:0];
    assign bus.inj_en        = r_inj_en;
    assign bus.busy          = r_busy;
    assign bus.cal_done      = r_done;
    assign bus.cal_err       = r_err;

endmodule
